// File: rtl/mole_scheduler_if.sv
// Handshake bundle between the mole scheduler and its environment.
//   start      : round enable level (high = play)
//   pause      : freeze request from the round timer
//   difficulty : level 0-3, sampled when a round starts
//   tap        : debounced per-hole tap levels
//   holes      : mask of currently raised moles
//   hits       : one-cycle mask of raised moles that were tapped
//   misses     : one-cycle mask of taps on empty holes
//   escapes    : one-cycle mask of moles whose dwell ran out
//   active     : number of raised moles
// master = game/test side, slave = mole_scheduler.
interface mole_scheduler_if;
  logic       start;
  logic       pause;
  logic [1:0] difficulty;
  logic [7:0] tap;
  logic [7:0] holes;
  logic [7:0] hits;
  logic [7:0] misses;
  logic [7:0] escapes;
  logic [2:0] active;

  modport master (
    output start, pause, difficulty, tap,
    input  holes, hits, misses, escapes, active
  );

  modport slave (
    input  start, pause, difficulty, tap,
    output holes, hits, misses, escapes, active
  );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: decides when and where moles appear, how long they
// stay up, and turns taps / timeouts into hit, miss and escape pulses.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : mole_scheduler_if.slave (start, pause, difficulty, tap in;
//         holes, hits, misses, escapes, active out)
// Parameters:
//   TICK_DIV : clocks per 1 ms tick
//   SEED     : nonzero LFSR reset value
// Build option:
//   MOLE_SCHED_FIXED_SEQ_EN : when defined, holes are picked by a round-robin
//   pointer instead of the LFSR (deterministic bring-up sequence).
module mole_scheduler #(
  parameter int unsigned TICK_DIV = 100000,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input logic             clk,
  input logic             rst,
  mole_scheduler_if.slave bus
);

  localparam int unsigned      TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StSearch, StPaused} state_e;

  function automatic logic [10:0] spawn_ms(input logic [1:0] d);
    unique case (d)
      2'd0: return 11'd1000;
      2'd1: return 11'd700;
      2'd2: return 11'd450;
      default: return 11'd250;
    endcase
  endfunction

  function automatic logic [10:0] dwell_ms(input logic [1:0] d);
    unique case (d)
      2'd0: return 11'd1200;
      2'd1: return 11'd800;
      2'd2: return 11'd500;
      default: return 11'd300;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        diff_q, diff_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [10:0]       spawn_q, spawn_d;
  logic [7:0][10:0]  dwell_q, dwell_d;
  logic [7:0]        holes_q, holes_d;
  logic [7:0]        hits_q, hits_d;
  logic [7:0]        misses_q, misses_d;
  logic [7:0]        escapes_q, escapes_d;
  logic [7:0]        tap_q, tap_prev_q;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        active;
  logic [2:0]        max_up;
  logic [2:0]        cand;
  logic [7:0]        tap_edge;
  logic              tick;

`ifdef MOLE_SCHED_FIXED_SEQ_EN
  logic [2:0] rr_q, rr_d;
  assign cand = rr_q;
`else
  logic [7:0] lfsr_q, lfsr_d;
  assign cand = lfsr_q[2:0];
`endif

  assign tap_edge = tap_q & ~tap_prev_q;
  assign max_up   = 3'(diff_q) + 3'd1;

  always_comb begin
    active = '0;
    for (int i = 0; i < 8; i++) active = active + 3'(holes_q[i]);
  end

  always_comb begin
    state_d    = state_q;
    diff_d     = diff_q;
    tick_cnt_d = tick_cnt_q;
    spawn_d    = spawn_q;
    dwell_d    = dwell_q;
    holes_d    = holes_q;
    idx_d      = idx_q;
    hits_d     = '0;
    misses_d   = '0;
    escapes_d  = '0;
    tick       = 1'b0;
`ifdef MOLE_SCHED_FIXED_SEQ_EN
    rr_d       = rr_q;
`else
    lfsr_d     = lfsr_q;
`endif

    if (!bus.start) begin
      state_d    = StIdle;
      holes_d    = '0;
      dwell_d    = '0;
      tick_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d    = StRun;
          diff_d     = bus.difficulty;
          tick_cnt_d = '0;
          spawn_d    = spawn_ms(bus.difficulty);
        end
        StPaused: begin
          if (!bus.pause) state_d = StRun;
        end
        StRun, StSearch: begin
          // Pause freezes everything from this cycle on, including the LFSR.
          if (state_q == StRun && bus.pause) begin
            state_d = StPaused;
          end else begin
            tick       = (tick_cnt_q == TickMax);
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            hits_d     = tap_edge & holes_q;
            misses_d   = tap_edge & ~holes_q;
            holes_d    = holes_q & ~tap_edge;
            // A tapped hole is a hit even if its dwell would expire now.
            for (int i = 0; i < 8; i++) begin
              if (holes_q[i] && !tap_edge[i] && tick) begin
                dwell_d[i] = dwell_q[i] - 11'd1;
                if (dwell_q[i] == 11'd1) begin
                  holes_d[i]   = 1'b0;
                  escapes_d[i] = 1'b1;
                end
              end
            end
            if (tick && spawn_q != '0) spawn_d = spawn_q - 11'd1;
`ifndef MOLE_SCHED_FIXED_SEQ_EN
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
            if (state_q == StRun) begin
              if (spawn_q == '0 && active < max_up) begin
                state_d = StSearch;
                idx_d   = cand;
              end
            end else if (!holes_q[idx_q]) begin
              // A tap edge on this hole already counted as a miss above.
              holes_d[idx_q] = 1'b1;
              dwell_d[idx_q] = dwell_ms(diff_q);
              spawn_d        = spawn_ms(diff_q);
              state_d        = StRun;
`ifdef MOLE_SCHED_FIXED_SEQ_EN
              rr_d           = idx_q + 3'd1;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      diff_q     <= '0;
      tick_cnt_q <= '0;
      spawn_q    <= '0;
      dwell_q    <= '0;
      holes_q    <= '0;
      hits_q     <= '0;
      misses_q   <= '0;
      escapes_q  <= '0;
      tap_q      <= '0;
      tap_prev_q <= '0;
      idx_q      <= '0;
`ifdef MOLE_SCHED_FIXED_SEQ_EN
      rr_q       <= '0;
`else
      lfsr_q     <= SEED;
`endif
    end else begin
      state_q    <= state_d;
      diff_q     <= diff_d;
      tick_cnt_q <= tick_cnt_d;
      spawn_q    <= spawn_d;
      dwell_q    <= dwell_d;
      holes_q    <= holes_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      escapes_q  <= escapes_d;
      tap_q      <= bus.tap;
      tap_prev_q <= tap_q;
      idx_q      <= idx_d;
`ifdef MOLE_SCHED_FIXED_SEQ_EN
      rr_q       <= rr_d;
`else
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign bus.holes   = holes_q;
  assign bus.hits    = hits_q;
  assign bus.misses  = misses_q;
  assign bus.escapes = escapes_q;
  assign bus.active  = active;

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler with TICK_DIV = 4. A millisecond-level
// game model (mode, tick phase, per-hole remaining dwell) predicts every cycle.
module tb_mole_scheduler;

  localparam int TickDiv = 4;
  localparam int MIdle = 0, MRun = 1, MSearch = 2, MPaused = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mole_scheduler_if bus ();

  mole_scheduler #(.TICK_DIV(TickDiv), .SEED(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int       m_mode = MIdle;
  int       m_d = 0;
  int       m_tick = 0;
  int       m_spawn = 0;
  int       m_dwell [8];
  int       m_idx = 0;
  int       m_rr = 0;
  bit [7:0] m_lfsr = 8'hA5;
  bit [7:0] m_holes = 0, m_hits = 0, m_misses = 0, m_escapes = 0;
  bit [7:0] m_tap1 = 0, m_tap2 = 0;

  function automatic int spawn_of(input int d);
    case (d)
      0: return 1000;
      1: return 700;
      2: return 450;
      default: return 250;
    endcase
  endfunction

  function automatic int dwell_of(input int d);
    case (d)
      0: return 1200;
      1: return 800;
      2: return 500;
      default: return 300;
    endcase
  endfunction

  task automatic model_step();
    bit [7:0] edges, nh, old_lfsr;
    bit       ticked;
    int       old_spawn;
    edges = m_tap1 & ~m_tap2;
    m_tap2 = m_tap1;
    m_tap1 = bus.tap;
    m_hits = 0; m_misses = 0; m_escapes = 0;
    if (rst) begin
      m_mode = MIdle; m_holes = 0; m_tap1 = 0; m_tap2 = 0; m_lfsr = 8'hA5;
      m_rr = 0; m_tick = 0; m_spawn = 0; m_idx = 0; m_d = 0;
      for (int i = 0; i < 8; i++) m_dwell[i] = 0;
    end else if (!bus.start) begin
      m_mode = MIdle; m_holes = 0; m_tick = 0;
      for (int i = 0; i < 8; i++) m_dwell[i] = 0;
    end else if (m_mode == MIdle) begin
      m_mode = MRun; m_d = int'(bus.difficulty); m_tick = 0; m_spawn = spawn_of(m_d);
    end else if (m_mode == MPaused) begin
      if (!bus.pause) m_mode = MRun;
    end else if (m_mode == MRun && bus.pause) begin
      m_mode = MPaused;
    end else begin
      m_tick++;
      ticked = (m_tick == TickDiv);
      if (ticked) m_tick = 0;
      m_hits = edges & m_holes;
      m_misses = edges & ~m_holes;
      nh = m_holes & ~edges;
      for (int i = 0; i < 8; i++) begin
        if (nh[i] && ticked) begin
          m_dwell[i]--;
          if (m_dwell[i] == 0) begin nh[i] = 0; m_escapes[i] = 1; end
        end
      end
      old_spawn = m_spawn;
      if (ticked && m_spawn > 0) m_spawn--;
      old_lfsr = m_lfsr;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      if (m_mode == MRun) begin
        if (old_spawn == 0 && $countones(m_holes) < m_d + 1) begin
          m_mode = MSearch;
`ifdef MOLE_SCHED_FIXED_SEQ_EN
          m_idx = m_rr;
`else
          m_idx = int'(old_lfsr[2:0]);
`endif
        end
      end else if (!m_holes[m_idx]) begin
        nh[m_idx] = 1; m_dwell[m_idx] = dwell_of(m_d); m_spawn = spawn_of(m_d);
        m_mode = MRun; m_rr = (m_idx + 1) % 8;
      end else begin
        m_idx = (m_idx + 1) % 8;
      end
      m_holes = nh;
    end
  endtask

  function automatic logic [34:0] dut_vec();
    return {bus.holes, bus.hits, bus.misses, bus.escapes, bus.active};
  endfunction

  function automatic logic [34:0] mdl_vec();
    return {m_holes, m_hits, m_misses, m_escapes, 3'($countones(m_holes))};
  endfunction

  function automatic int first_bit(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; bus.start = 1'b0; bus.pause = 1'b0; bus.difficulty = 2'd0; bus.tap = 8'h00;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic wait_for_mole(input int bound, output int n);
    n = 0;
    while (bus.holes == 8'h00 && n < bound) begin cycle(); n++; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec() !== 35'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", dut_vec());
    end
    repeat (3) cycle();
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL reset_idle got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_first_spawn();
    int n; bit [7:0] placed;
    apply_reset();
    bus.difficulty = 2'd0; bus.start = 1'b1;
    wait_for_mole(4100, n);
    checks++;
    if (n < 4003 || n > 4010) begin
      errors++; $display("FAIL first_spawn_time got %0d want 4003..4010", n);
    end
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL first_spawn_state got %h want %h", dut_vec(), mdl_vec());
    end
`ifdef MOLE_SCHED_FIXED_SEQ_EN
    checks++;
    if (bus.holes !== 8'h01) begin
      errors++; $display("FAIL fixed_first_hole got %h want 01", bus.holes);
    end
`endif
    placed = m_holes;
    n = 0;
    while (bus.escapes == 8'h00 && n < 4900) begin
      cycle(); n++;
      checks++;
      if (bus.active > 3'd1) begin
        errors++; $display("FAIL active_limit_d0 got %0d want <=1", bus.active);
      end
    end
    checks++;
    if (n < 4797 || n > 4800) begin
      errors++; $display("FAIL escape_time got %0d want 4797..4800", n);
    end
    checks++;
    if (bus.escapes !== placed || bus.holes !== 8'h00) begin
      errors++; $display("FAIL escape_mask got esc=%h holes=%h want esc=%h holes=00",
                         bus.escapes, bus.holes, placed);
    end
    wait_for_mole(20, n);
    checks++;
    if (n < 2 || n > 9) begin
      errors++; $display("FAIL respawn_after_free got %0d want 2..9", n);
    end
`ifdef MOLE_SCHED_FIXED_SEQ_EN
    checks++;
    if (bus.holes !== 8'h02) begin
      errors++; $display("FAIL fixed_second_hole got %h want 02", bus.holes);
    end
`endif
  endtask

  task automatic test_taps();
    int n, i, j; bit [7:0] two;
    apply_reset();
    bus.difficulty = 2'd1; bus.start = 1'b1;
    wait_for_mole(2900, n);
    checks++;
    if (n < 2803 || n > 2810) begin
      errors++; $display("FAIL spawn_time_d1 got %0d want 2803..2810", n);
    end
    i = first_bit(m_holes);
    bus.tap[i] = 1'b1;
    cycle(); cycle();
    checks++;
    if (bus.hits !== (8'd1 << i) || bus.holes[i] !== 1'b0 || bus.misses !== 8'h00
        || bus.active !== 3'd0) begin
      errors++; $display("FAIL tap_hit got hits=%h holes=%h misses=%h want hits=%h holes[i]=0",
                         bus.hits, bus.holes, bus.misses, 8'd1 << i);
    end
    j = (i + 3) % 8;
    bus.tap[j] = 1'b1;
    cycle();
    checks++;
    if ((bus.hits | bus.misses) !== 8'h00) begin
      errors++; $display("FAIL tap_latency got %h want 00", bus.hits | bus.misses);
    end
    cycle();
    checks++;
    if (bus.misses !== (8'd1 << j) || bus.hits !== 8'h00) begin
      errors++; $display("FAIL tap_miss got misses=%h hits=%h want misses=%h",
                         bus.misses, bus.hits, 8'd1 << j);
    end
    repeat (6) begin
      cycle();
      checks++;
      if ((bus.hits | bus.misses) !== 8'h00) begin
        errors++; $display("FAIL tap_held got %h want 00", bus.hits | bus.misses);
      end
    end
    two = (8'd1 << ((i + 5) % 8)) | (8'd1 << ((i + 6) % 8));
    bus.tap = bus.tap | two;
    cycle(); cycle();
    checks++;
    if (bus.misses !== two) begin
      errors++; $display("FAIL tap_multi got %h want %h", bus.misses, two);
    end
    bus.tap = 8'h00;
    cycle(); cycle();
  endtask

  task automatic test_hit_vs_expiry();
    int n, i; bit found;
    apply_reset();
    bus.difficulty = 2'd3; bus.start = 1'b1;
    wait_for_mole(1100, n);
    checks++;
    if (n < 1003 || n > 1010) begin
      errors++; $display("FAIL spawn_time_d3 got %0d want 1003..1010", n);
    end
    i = first_bit(m_holes);
    found = 1'b0;
    for (int c = 0; c < 1300; c++) begin
      if (m_holes[i] && m_dwell[i] == 1 && m_tick == TickDiv - 2) begin found = 1'b1; break; end
      cycle();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL hit_vs_expiry_setup got no expiry window want one");
    end else begin
      bus.tap[i] = 1'b1;
      cycle(); cycle();
      checks++;
      if (bus.hits[i] !== 1'b1 || bus.escapes[i] !== 1'b0 || bus.holes[i] !== 1'b0) begin
        errors++; $display("FAIL hit_vs_expiry got hits=%h esc=%h holes=%h want hit bit %0d",
                           bus.hits, bus.escapes, bus.holes, i);
      end
    end
    bus.tap = 8'h00;
    cycle(); cycle();
  endtask

  task automatic test_pause_resume();
    int n, e; bit [7:0] h;
    apply_reset();
    bus.difficulty = 2'd2; bus.start = 1'b1;
    wait_for_mole(1900, n);
    checks++;
    if (n < 1803 || n > 1810) begin
      errors++; $display("FAIL spawn_time_d2 got %0d want 1803..1810", n);
    end
    e = 0;
    repeat (200) begin cycle(); e++; end
    h = bus.holes;
    checks++;
    if (h !== m_holes) begin
      errors++; $display("FAIL pre_pause_holes got %h want %h", h, m_holes);
    end
    bus.pause = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      bus.tap = (c < 1990) ? 8'($urandom_range(0, 255)) : 8'h00;
      cycle(); e++;
      checks++;
      if (bus.holes !== h || (bus.hits | bus.misses | bus.escapes) !== 8'h00) begin
        errors++; $display("FAIL paused_frozen got holes=%h ev=%h want holes=%h ev=00",
                           bus.holes, bus.hits | bus.misses | bus.escapes, h);
      end
    end
    bus.pause = 1'b0;
    while (bus.escapes == 8'h00 && e < 4500) begin
      cycle(); e++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL resume_lockstep got %h want %h", dut_vec(), mdl_vec());
      end
    end
    // 2000 paused edges plus the PAUSED->RUN edge do not count toward dwell.
    checks++;
    if (e - 2001 < 1997 || e - 2001 > 2000 || bus.escapes !== h) begin
      errors++; $display("FAIL resume_dwell got active=%0d esc=%h want 1997..2000 esc=%h",
                         e - 2001, bus.escapes, h);
    end
  endtask

  task automatic test_stop_restart();
    int n;
    bus.start = 1'b0;
    cycle();
    checks++;
    if (bus.holes !== 8'h00 || bus.active !== 3'd0) begin
      errors++; $display("FAIL stop_clears got holes=%h active=%0d want 00/0",
                         bus.holes, bus.active);
    end
    bus.difficulty = 2'd3; bus.start = 1'b1;
    wait_for_mole(1100, n);
    checks++;
    if (n < 1003 || n > 1010) begin
      errors++; $display("FAIL restart_new_diff got %0d want 1003..1010", n);
    end
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL restart_state got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_random();
    apply_reset();
    bus.difficulty = 2'd3; bus.start = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 499) == 0) bus.start = ~bus.start;
      if (!bus.start && $urandom_range(0, 9) == 0) bus.start = 1'b1;
      if ($urandom_range(0, 299) == 0) bus.pause = ~bus.pause;
      if ($urandom_range(0, 99) == 0) bus.difficulty = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) bus.tap = bus.tap ^ (8'd1 << $urandom_range(0, 7));
      cycle();
      checks++;
      if (dut_vec() !== mdl_vec() || int'(bus.active) > m_d + 1) begin
        errors++; $display("FAIL random_lockstep c=%0d got %h want %h", c, dut_vec(), mdl_vec());
      end
    end
    bus.pause = 1'b0; bus.tap = 8'h00;
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; bus.difficulty = 2'd3;
    repeat (1100) cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if (dut_vec() !== 35'd0) begin
      errors++; $display("FAIL reset_mid got %h want 0", dut_vec());
    end
    rst = 1'b0;
    repeat (3) cycle();
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL after_reset_mid got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.difficulty = 2'd0; bus.tap = 8'h00;
    for (int i = 0; i < 8; i++) m_dwell[i] = 0;
    test_reset();
    test_first_spawn();
    test_taps();
    test_hit_vs_expiry();
    test_pause_resume();
    test_stop_restart();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
